// File: rtl/mem_responder_if.sv
// Requester/responder bus for mem_responder: level requests in, one-cycle finish pulses out.
interface mem_responder_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_data;
  logic              mem_read_fin;
  logic              mem_write_fin;
  logic              busy;

  modport master (
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_data, mem_read_fin, mem_write_fin, busy
  );

  modport slave (
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_data, mem_read_fin, mem_write_fin, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency backing-store model answering cache refill/write-back requests.
// Write-back path is present only when MEM_RESPONDER_WB_EN is defined; otherwise read-only.
module mem_responder #(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4
) (
  input logic              clk,
  input logic              rst,
  mem_responder_if.slave   bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DATA_W-1:0] InitWord = DATA_W'(32'h12345678);
  localparam logic [7:0] CntLoad = 8'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  start_wr;

  // Contents survive rst; only the power-on value is defined.
  logic [DATA_W-1:0] store [Depth] = '{default: InitWord};

`ifdef MEM_RESPONDER_WB_EN
  logic [DATA_W-1:0] wdata_q, wdata_d;

  assign start_wr = bus.mem_wr;

  always_comb begin
    wdata_d = wdata_q;
    if (state_q == StIdle && start_wr) begin
      wdata_d = bus.mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q <= '0;
    end else begin
      wdata_q <= wdata_d;
    end
  end

  // Commit on the DONE-exit edge; a reset on that edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StDone && op_wr_q) begin
      store[addr_q] <= wdata_q;
    end
  end

  assign bus.mem_write_fin = (state_q == StDone) && op_wr_q;
`else
  logic unused_wb;

  assign start_wr          = 1'b0;
  assign unused_wb         = bus.mem_wr ^ (^bus.mem_wdata);
  assign bus.mem_write_fin = 1'b0;
`endif

  generate
    if (ADDR_W > DEPTH_LOG2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.mem_addr[ADDR_W-1:DEPTH_LOG2];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        // Write wins a tie; a still-held read is picked up after DONE.
        if (start_wr || bus.mem_rd) begin
          state_d = StWait;
          cnt_d   = CntLoad;
          op_wr_d = start_wr;
          addr_d  = bus.mem_addr[DEPTH_LOG2-1:0];
        end
      end
      StWait: begin
        if (cnt_q == 8'd0) begin
          state_d = StDone;
          if (!op_wr_q) begin
            data_d = store[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.mem_data     = data_q;
  assign bus.mem_read_fin = (state_q == StDone) && !op_wr_q;
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; covers the write-back path when MEM_RESPONDER_WB_EN is set.
module tb_mem_responder;

  localparam int unsigned Latency = 4;
  localparam logic [31:0] InitWord = 32'h12345678;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(30), .DATA_W(32)) bus ();

  mem_responder #(
    .ADDR_W    (30),
    .DATA_W    (32),
    .DEPTH_LOG2(10),
    .LATENCY   (Latency)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [29:0] addr,
                       input logic [31:0] wdata);
    bus.mem_rd    = rd;
    bus.mem_wr    = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
  endtask

  // Waits for one transaction; scramble perturbs the request lines while it is in flight.
  task automatic await_fin(input string tag, input logic exp_wr, input logic [31:0] exp_data,
                           input logic scramble);
    int cyc;
    tick();
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    if (scramble) begin
      bus.mem_addr  = 30'h7;
      bus.mem_wdata = 32'hdeadbeef;
    end
    cyc = 0;
    while (!(bus.mem_read_fin || bus.mem_write_fin) && cyc < 50) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(Latency));
    check({tag, "_fin"}, {30'd0, bus.mem_write_fin, bus.mem_read_fin},
          exp_wr ? 32'd2 : 32'd1);
    if (!exp_wr) begin
      check({tag, "_data"}, bus.mem_data, exp_data);
    end
    if (exp_wr) bus.mem_wr = 1'b0;
    else        bus.mem_rd = 1'b0;
    tick();
    check({tag, "_pulse"}, {30'd0, bus.mem_write_fin, bus.mem_read_fin}, 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    if (!exp_wr) begin
      check({tag, "_hold"}, bus.mem_data, exp_data);
    end
  endtask

  task automatic abort_in_wait(input string tag, input logic rd, input logic wr,
                               input logic [29:0] addr);
    issue(rd, wr, addr, 32'h0badf00d);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(1'b0, 1'b0, 30'd0, 32'd0);
    check({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_rst_data"}, bus.mem_data, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_nofin"}, {30'd0, bus.mem_write_fin, bus.mem_read_fin}, 32'd0);
      tick();
    end
  endtask

  initial begin
    issue(1'b0, 1'b0, 30'd0, 32'd0);
    tick();
    tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_rfin", 32'(bus.mem_read_fin), 32'd0);
    check("reset_wfin", 32'(bus.mem_write_fin), 32'd0);
    check("reset_data", bus.mem_data, 32'd0);
    rst = 1'b0;
    tick();

    issue(1'b1, 1'b0, 30'd0, 32'd0);
    await_fin("rd0", 1'b0, InitWord, 1'b0);
    issue(1'b1, 1'b0, 30'd1023, 32'd0);
    await_fin("rd1023", 1'b0, InitWord, 1'b0);

`ifdef MEM_RESPONDER_WB_EN
    issue(1'b0, 1'b1, 30'd1, 32'h87654321);
    await_fin("wr1", 1'b1, 32'd0, 1'b0);
    issue(1'b1, 1'b0, 30'd1, 32'd0);
    await_fin("rd1", 1'b0, 32'h87654321, 1'b1);

    issue(1'b1, 1'b1, 30'd5, 32'ha5a5_0005);
    await_fin("both_wr5", 1'b1, 32'd0, 1'b0);
    await_fin("both_rd5", 1'b0, 32'ha5a5_0005, 1'b0);

    issue(1'b0, 1'b1, 30'd1024, 32'hcafe_f00d);
    await_fin("wr1024", 1'b1, 32'd0, 1'b0);
    issue(1'b1, 1'b0, 30'd0, 32'd0);
    await_fin("rd_wrap0", 1'b0, 32'hcafe_f00d, 1'b0);

    abort_in_wait("abort_wr2", 1'b0, 1'b1, 30'd2);
    issue(1'b1, 1'b0, 30'd2, 32'd0);
    await_fin("rd2", 1'b0, InitWord, 1'b0);
`else
    issue(1'b0, 1'b1, 30'd1, 32'h87654321);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("wr_only_busy", 32'(bus.busy), 32'd0);
      check("wr_only_wfin", 32'(bus.mem_write_fin), 32'd0);
    end
    issue(1'b1, 1'b1, 30'd5, 32'ha5a5_0005);
    await_fin("both_rd5", 1'b0, InitWord, 1'b0);
    issue(1'b0, 1'b0, 30'd0, 32'd0);
    tick();
    check("both_after_busy", 32'(bus.busy), 32'd0);

    abort_in_wait("abort_rd3", 1'b1, 1'b0, 30'd3);
    issue(1'b1, 1'b0, 30'd1024, 32'd0);
    await_fin("rd_wrap1024", 1'b0, InitWord, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
